// File: rtl/booth_pp_generator_if.sv
// Operand/partial-product bus for the radix-4 Booth partial-product generator.
// Groups the operand-side valid/ready handshake (in_valid, in_ready, a, b,
// in_tag) and the result-side handshake (out_valid, out_ready, pp, cpl,
// out_tag).
//   master : the producer of operands and consumer of partial products.
//   slave  : the generator itself.
// Parameters mirror the generator: W (operand width, even, >= 4), UNSIGNED
// (1 = unsigned operands), TAG_W (user tag width).
interface booth_pp_generator_if #(
  parameter int W        = 8,
  parameter int UNSIGNED = 0,
  parameter int TAG_W    = 8
);
  localparam int NUM_CPL  = W / 2;
  localparam int NUM_PP   = NUM_CPL + UNSIGNED;
  localparam int PP_WIDTH = W + 1;

  logic                in_valid;
  logic                in_ready;
  logic [W-1:0]        a;
  logic [W-1:0]        b;
  logic [TAG_W-1:0]    in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [PP_WIDTH-1:0] pp [NUM_PP-1:0];
  logic [NUM_CPL-1:0]  cpl;
  logic [TAG_W-1:0]    out_tag;

  modport master (
    output in_valid, a, b, in_tag, out_ready,
    input  in_ready, out_valid, pp, cpl, out_tag
  );

  modport slave (
    input  in_valid, a, b, in_tag, out_ready,
    output in_ready, out_valid, pp, cpl, out_tag
  );
endinterface

// File: rtl/booth_pp_generator.sv
// Radix-4 Booth partial-product generator.
// Recodes the multiplier b into radix-4 digits combinationally at the input,
// selects/inverts the multiplicand per digit, and stores the resulting
// {pp, cpl, tag} in a 2-entry FIFO skid buffer feeding the compressor tree.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; empties the buffer, clears outputs
//   bus   : booth_pp_generator_if.slave -- operand handshake in, partial
//           products out (pp[NUM_PP-1:0], cpl[NUM_CPL-1:0], out_tag)
module booth_pp_generator #(
  parameter int W        = 8,
  parameter int UNSIGNED = 0,
  parameter int TAG_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  booth_pp_generator_if.slave  bus
);
  localparam int NUM_CPL  = W / 2;
  localparam int NUM_PP   = NUM_CPL + UNSIGNED;
  localparam int PP_WIDTH = W + 1;
  localparam int BX_W     = 2 * NUM_PP + 1;

  typedef struct packed {
    logic [NUM_PP-1:0][PP_WIDTH-1:0] pp;
    logic [NUM_CPL-1:0]              cpl;
    logic [TAG_W-1:0]                tag;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Radix-4 digit from the triplet (b[2i+1], b[2i], b[2i-1]).
  function automatic logic signed [2:0] booth_digit(input logic [2:0] t);
    logic signed [2:0] d;
    case (t)
      3'b001, 3'b010: d = 3'sd1;
      3'b011:         d = 3'sd2;
      3'b100:         d = -3'sd2;
      3'b101, 3'b110: d = -3'sd1;
      default:        d = 3'sd0;
    endcase
    return d;
  endfunction

  logic                       ext;
  logic [BX_W-1:0]            bx;
  logic signed [PP_WIDTH-1:0] a1;
  entry_t                     new_e;

  // b shifted up one place with b[-1] = 0 at bit 0; bits above the operand
  // replicate the sign (signed) or are zero (unsigned extra digit).
  assign ext = (UNSIGNED != 0) ? 1'b0 : bus.b[W-1];

  always_comb begin
    bx      = '0;
    bx[W:1] = bus.b;
    for (int k = W + 1; k < BX_W; k++) begin
      bx[k] = ext;
    end
  end

  assign a1 = (UNSIGNED != 0) ? $signed({1'b0, bus.a}) : $signed({bus.a[W-1], bus.a});

  for (genvar i = 0; i < NUM_PP; i++) begin : g_digit
    logic signed [2:0]          dig;
    logic signed [PP_WIDTH-1:0] mag;

    assign dig = booth_digit(bx[2*i +: 3]);
    assign mag = (dig == 3'sd0) ? '0 :
                 ((dig == 3'sd2) || (dig == -3'sd2)) ? (a1 <<< 1) : a1;
    // Negative digits send ~mag; the +1 completing the negation rides on cpl.
    assign new_e.pp[i] = dig[2] ? ~mag : mag;
    if (i < NUM_CPL) begin : g_cpl
      assign new_e.cpl[i] = dig[2];
    end
  end

  assign new_e.tag = bus.in_tag;

  state_t state_q, state_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;
  logic   in_ready_q, in_ready_d;
  logic   push, pop, out_valid;

  assign out_valid = (state_q != EMPTY);
  assign push      = bus.in_valid & in_ready_q;
  assign pop       = out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = new_e;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = new_e;
        end else if (push) begin
          state_d = FULL;
          tail_d  = new_e;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only a pop can happen.
        if (pop) begin
          state_d = ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d = (state_d != FULL);
  end

  // Buffer stage: occupancy, registered in_ready, head/tail entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid;
  assign bus.cpl       = head_q.cpl;
  assign bus.out_tag   = head_q.tag;

  for (genvar i = 0; i < NUM_PP; i++) begin : g_out
    assign bus.pp[i] = head_q.pp[i];
  end
endmodule

// File: tb/tb_booth_pp_generator.sv
// Bench for booth_pp_generator: one signed and one unsigned W=8 instance.
// Hand-computed vectors, backpressure and reset sequences, and a random
// stream checked through the partial-product sum invariant and tag order.
module tb_booth_pp_generator;
  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  booth_pp_generator_if #(.W(8), .UNSIGNED(0), .TAG_W(8)) if_s ();
  booth_pp_generator_if #(.W(8), .UNSIGNED(1), .TAG_W(8)) if_u ();

  booth_pp_generator #(.W(8), .UNSIGNED(0), .TAG_W(8)) u_s (
    .clk(clk), .rst_n(rst_n), .bus(if_s)
  );
  booth_pp_generator #(.W(8), .UNSIGNED(1), .TAG_W(8)) u_u (
    .clk(clk), .rst_n(rst_n), .bus(if_u)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [4:0][8:0] pk_s, pk_u;
  always_comb begin
    pk_s = '0;
    pk_u = '0;
    for (int i = 0; i < 4; i++) pk_s[i] = if_s.pp[i];
    for (int i = 0; i < 5; i++) pk_u[i] = if_u.pp[i];
  end

  typedef struct {
    bit              uns;
    logic [7:0]      a;
    logic [7:0]      b;
    logic [7:0]      tag;
    logic [4:0][8:0] pp;
    logic [3:0]      cpl;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic drv(input bit uns, input logic v, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] tag);
    if (uns) begin
      if_u.in_valid = v; if_u.a = a; if_u.b = b; if_u.in_tag = tag;
    end else begin
      if_s.in_valid = v; if_s.a = a; if_s.b = b; if_s.in_tag = tag;
    end
  endtask

  task automatic rd(input bit uns, output logic ov, output logic ir,
                    output logic [4:0][8:0] p, output logic [3:0] c,
                    output logic [7:0] t);
    if (uns) begin
      ov = if_u.out_valid; ir = if_u.in_ready; p = pk_u; c = if_u.cpl; t = if_u.out_tag;
    end else begin
      ov = if_s.out_valid; ir = if_s.in_ready; p = pk_s; c = if_s.cpl; t = if_s.out_tag;
    end
  endtask

  // Sum of pp[i]*4^i + cpl[i]*4^i mod 2^16. Signed pp are sign-extended.
  // Unsigned pp of positive digits are zero-extended; an inverted magnitude
  // (cpl set) always stands for a negative value, so it is extended with ones.
  function automatic longint inv(input bit uns, input logic [4:0][8:0] p,
                                 input logic [3:0] c);
    longint s;
    longint v;
    int     n;
    s = 0;
    n = uns ? 5 : 4;
    for (int i = 0; i < n; i++) begin
      v = longint'(p[i]);
      if (!uns && p[i][8]) v = v - 512;
      if (uns && i < 4 && c[i]) v = v - 512;
      s = s + v * (longint'(1) << (2 * i));
      if (i < 4) s = s + longint'(c[i]) * (longint'(1) << (2 * i));
    end
    return s & 64'hFFFF;
  endfunction

  function automatic longint prod(input bit uns, input logic [7:0] a, input logic [7:0] b);
    longint pa, pb;
    pa = longint'(a);
    pb = longint'(b);
    if (!uns && a[7]) pa = pa - 256;
    if (!uns && b[7]) pb = pb - 256;
    return (pa * pb) & 64'hFFFF;
  endfunction

  task automatic apply(input vec_t v);
    logic ov, ir;
    logic [4:0][8:0] p;
    logic [3:0] c;
    logic [7:0] t;
    rd(v.uns, ov, ir, p, c, t);
    chk($sformatf("vec%0h in_ready", v.tag), ir, 1'b1);
    drv(v.uns, 1'b1, v.a, v.b, v.tag);
    @(posedge clk); #1;
    drv(v.uns, 1'b0, 8'h00, 8'h00, 8'h00);
    rd(v.uns, ov, ir, p, c, t);
    chk($sformatf("vec%0h out_valid", v.tag), ov, 1'b1);
    chk($sformatf("vec%0h pp", v.tag), p, v.pp);
    chk($sformatf("vec%0h cpl", v.tag), c, v.cpl);
    chk($sformatf("vec%0h tag", v.tag), t, v.tag);
    chk($sformatf("vec%0h product", v.tag), inv(v.uns, p, c), prod(v.uns, v.a, v.b));
  endtask

  task automatic rand_run(input bit uns, input int n);
    longint     qp[$];
    logic [7:0] qt[$];
    int         pushed, popped, cyc;
    bit         v, r, acc, pp_ev;
    logic [7:0] ca, cb, ct;
    logic       ov, ir;
    logic [4:0][8:0] p;
    logic [3:0] c;
    logic [7:0] t;
    pushed = 0; popped = 0; cyc = 0; v = 0;
    ca = '0; cb = '0; ct = '0;
    while (popped < n && cyc < 20000) begin
      if (!v && pushed < n && $urandom_range(0, 3) != 0) begin
        v  = 1;
        ca = 8'($urandom);
        cb = 8'($urandom);
        ct = 8'(pushed);
      end
      drv(uns, v, ca, cb, ct);
      r = ($urandom_range(0, 3) != 0);
      if (uns) if_u.out_ready = r; else if_s.out_ready = r;
      #3;
      rd(uns, ov, ir, p, c, t);
      acc   = v && ir;
      pp_ev = ov && r;
      if (pp_ev) begin
        if (qp.size() == 0) begin
          chk($sformatf("rand%0d unexpected output", uns), 1'b1, 1'b0);
        end else begin
          chk($sformatf("rand%0d invariant #%0d", uns, popped), inv(uns, p, c), qp.pop_front());
          chk($sformatf("rand%0d tag #%0d", uns, popped), t, qt.pop_front());
        end
        popped++;
      end
      if (acc) begin
        qp.push_back(prod(uns, ca, cb));
        qt.push_back(ct);
        pushed++;
        v = 0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    drv(uns, 1'b0, 8'h00, 8'h00, 8'h00);
    chk($sformatf("rand%0d outputs seen", uns), popped, n);
  endtask

  initial begin
    logic ov, ir;
    logic [4:0][8:0] p;
    logic [3:0] c;
    logic [7:0] t;
    logic [7:0] seen[$];
    bit   v3, acc, pop;
    int   cyc;

    vt[0] = '{1'b0, 8'h05, 8'h03, 8'h01, {9'h000, 9'h000, 9'h000, 9'h005, 9'h1FA}, 4'b0001};
    vt[1] = '{1'b0, 8'h80, 8'h02, 8'h02, {9'h000, 9'h000, 9'h000, 9'h180, 9'h0FF}, 4'b0001};
    vt[2] = '{1'b1, 8'hFF, 8'hFF, 8'h03, {9'h0FF, 9'h000, 9'h000, 9'h000, 9'h100}, 4'b0001};
    vt[3] = '{1'b0, 8'h07, 8'h80, 8'h04, {9'h000, 9'h1F1, 9'h000, 9'h000, 9'h000}, 4'b1000};
    vt[4] = '{1'b0, 8'hFD, 8'h7F, 8'h05, {9'h000, 9'h1FA, 9'h000, 9'h000, 9'h002}, 4'b0001};
    vt[5] = '{1'b1, 8'h80, 8'h0C, 8'h06, {9'h000, 9'h000, 9'h080, 9'h17F, 9'h000}, 4'b0010};
    vt[6] = '{1'b1, 8'hC3, 8'h5A, 8'h07, {9'h000, 9'h0C3, 9'h186, 9'h13C, 9'h079}, 4'b0011};
    vt[7] = '{1'b0, 8'h7F, 8'h7F, 8'h08, {9'h000, 9'h0FE, 9'h000, 9'h000, 9'h180}, 4'b0001};

    // Reset with in_valid held high on both instances.
    rst_n = 1'b1;
    drv(1'b0, 1'b1, 8'h12, 8'h34, 8'hAA);
    drv(1'b1, 1'b1, 8'h56, 8'h78, 8'hBB);
    if_s.out_ready = 1'b1;
    if_u.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rd(1'b0, ov, ir, p, c, t);
    chk("reset out_valid", ov, 1'b0);
    chk("reset in_ready", ir, 1'b1);
    chk("reset pp", p, '0);
    chk("reset cpl", c, 4'b0);
    chk("reset out_tag", t, 8'h00);
    rd(1'b1, ov, ir, p, c, t);
    chk("reset u out_valid", ov, 1'b0);
    chk("reset u in_ready", ir, 1'b1);
    drv(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    drv(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    rd(1'b0, ov, ir, p, c, t);
    chk("post-reset out_valid", ov, 1'b0);

    foreach (vt[i]) apply(vt[i]);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure on the signed instance.
    if_s.out_ready = 1'b0;
    drv(1'b0, 1'b1, 8'h01, 8'h01, 8'h01);
    @(posedge clk); #1;
    rd(1'b0, ov, ir, p, c, t);
    chk("bp in_ready after 1", ir, 1'b1);
    drv(1'b0, 1'b1, 8'h02, 8'h02, 8'h02);
    @(posedge clk); #1;
    rd(1'b0, ov, ir, p, c, t);
    chk("bp in_ready after 2", ir, 1'b0);
    chk("bp out_tag after 2", t, 8'h01);
    drv(1'b0, 1'b1, 8'h03, 8'h03, 8'h03);
    repeat (3) @(posedge clk);
    #1;
    rd(1'b0, ov, ir, p, c, t);
    chk("bp held in_ready", ir, 1'b0);
    chk("bp held out_valid", ov, 1'b1);
    chk("bp held out_tag", t, 8'h01);
    if_s.out_ready = 1'b1;
    v3 = 1;
    cyc = 0;
    while (seen.size() < 3 && cyc < 20) begin
      #3;
      rd(1'b0, ov, ir, p, c, t);
      acc = v3 && ir;
      pop = ov;
      @(posedge clk); #1;
      if (pop) seen.push_back(t);
      if (acc) begin
        v3 = 0;
        drv(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      end
      cyc++;
    end
    chk("bp drained count", seen.size(), 3);
    for (int i = 0; i < seen.size(); i++) chk($sformatf("bp drain order %0d", i), seen[i], i + 1);
    drv(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-operation with the signed buffer full.
    if_s.out_ready = 1'b0;
    drv(1'b0, 1'b1, 8'h11, 8'h11, 8'hA0);
    @(posedge clk); #1;
    drv(1'b0, 1'b1, 8'h22, 8'h22, 8'hA1);
    @(posedge clk); #1;
    rd(1'b0, ov, ir, p, c, t);
    chk("full before reset in_ready", ir, 1'b0);
    drv(1'b0, 1'b1, 8'h33, 8'h33, 8'hEE);
    #2 rst_n = 1'b0;
    #1;
    rd(1'b0, ov, ir, p, c, t);
    chk("mid reset out_valid", ov, 1'b0);
    chk("mid reset in_ready", ir, 1'b1);
    chk("mid reset out_tag", t, 8'h00);
    drv(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    #2 rst_n = 1'b1;
    if_s.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      rd(1'b0, ov, ir, p, c, t);
      chk($sformatf("no stale output %0d", i), ov, 1'b0);
    end
    drv(1'b0, 1'b1, 8'h05, 8'h03, 8'h55);
    @(posedge clk); #1;
    drv(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    rd(1'b0, ov, ir, p, c, t);
    chk("post-reset push valid", ov, 1'b1);
    chk("post-reset push tag", t, 8'h55);
    @(posedge clk); #1;

    rand_run(1'b0, 1000);
    rand_run(1'b1, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
